// File: rtl/mso_pkg.sv
// Shared MSO definitions: trigger-hub state encodings and capture FSM encodings.
package mso_pkg;

    typedef enum logic [1:0] {
        TRIG_DISARMED  = 2'd0,
        TRIG_ARMED     = 2'd1,
        TRIG_TRIGGERED = 2'd2,
        TRIG_CLEARED   = 2'd3
    } trig_state_e;

    typedef enum logic [2:0] {
        CAP_IDLE      = 3'd0,
        CAP_PRE_FILL  = 3'd1,
        CAP_WAIT_TRIG = 3'd2,
        CAP_POST_FILL = 3'd3,
        CAP_DONE      = 3'd4
    } cap_state_e;

    // Both TRIGGERED and CLEARED mean the hub has seen its trigger event.
    function automatic logic trig_fired(input logic [1:0] ts);
        return (ts == TRIG_TRIGGERED) || (ts == TRIG_CLEARED);
    endfunction

endpackage

// File: rtl/mso_ring_addr.sv
// Mod-DEPTH ring write pointer with clear/increment, plus the ring-distance
// subtract used to locate the oldest captured sample.
module mso_ring_addr #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] sub_base,
    input  logic [ADDR_WIDTH-1:0] sub_n,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic [ADDR_WIDTH-1:0] sub_result
);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    // Next pointer: clear has priority; natural overflow gives the DEPTH-1 -> 0 wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr        = ptr_q;
    assign sub_result = sub_base - sub_n;

endmodule

// File: rtl/mso_capture_ctrl.sv
// Capture sequencer behind the MSO trigger hub: pre-trigger ring fill, wait for
// trigger, post-trigger fill, stop; reports trigger and oldest-sample addresses.
module mso_capture_ctrl
    import mso_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_len,
    input  logic [ADDR_WIDTH-1:0] post_len,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic [1:0]            trigger_state,
    output logic                  hub_arm,
    output logic                  hub_reset,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] trigger_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            cap_state
);

    cap_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pre_len_q, pre_len_d, post_len_q, post_len_d;
    logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH-1:0] trigger_addr_q, trigger_addr_d, start_addr_q, start_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d, done_q, done_d, hub_reset_q, hub_reset_d;

    logic                  active, accept, start_ok, trig_hit, pre_reached, done_entry;
    logic [ADDR_WIDTH-1:0] wr_ptr, start_sub;

    assign active   = (state_q == CAP_PRE_FILL) || (state_q == CAP_WAIT_TRIG) ||
                      (state_q == CAP_POST_FILL);
    assign accept   = active && sample_valid && !abort;
    assign start_ok = start && !abort && ((state_q == CAP_IDLE) || (state_q == CAP_DONE));
    assign trig_hit = trig_fired(trigger_state);
    // pre_len==0 leaves on the first cycle; otherwise leave on the sample that completes the count.
    assign pre_reached = (pre_cnt_q == pre_len_q) ||
                         (sample_valid && ((pre_cnt_q + ADDR_WIDTH'(1)) == pre_len_q));
    assign done_entry  = (state_d == CAP_DONE) && (state_q != CAP_DONE);

    mso_ring_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .inc        (accept),
        .sub_base   (trigger_addr_d),
        .sub_n      (pre_len_q),
        .ptr        (wr_ptr),
        .sub_result (start_sub)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = CAP_IDLE;
        end else begin
            case (state_q)
                CAP_IDLE, CAP_DONE: if (start) state_d = CAP_PRE_FILL;
                CAP_PRE_FILL:       if (pre_reached) state_d = CAP_WAIT_TRIG;
                CAP_WAIT_TRIG: begin
                    if (trig_hit) begin
                        state_d = (sample_valid && (post_len_q == ADDR_WIDTH'(1))) ?
                                  CAP_DONE : CAP_POST_FILL;
                    end
                end
                CAP_POST_FILL: begin
                    if (sample_valid && ((post_cnt_q + ADDR_WIDTH'(1)) == post_len_q)) begin
                        state_d = CAP_DONE;
                    end
                end
                default:            state_d = CAP_IDLE;
            endcase
        end
    end

    // FSM output decode; hub_arm uses only our state and the hub's registered state.
    always_comb begin
        busy      = active;
        hub_arm   = (state_q == CAP_WAIT_TRIG) && (trigger_state == TRIG_DISARMED);
        cap_state = state_q;
    end

    // Datapath next-state: config latch, counters, write stage, address capture.
    always_comb begin
        pre_len_d      = pre_len_q;
        post_len_d     = post_len_q;
        pre_cnt_d      = pre_cnt_q;
        post_cnt_d     = post_cnt_q;
        trigger_addr_d = trigger_addr_q;
        start_addr_d   = start_addr_q;
        done_d         = done_q;
        wr_en_d        = accept;
        wr_addr_d      = accept ? wr_ptr : wr_addr_q;
        wr_data_d      = accept ? sample_data : wr_data_q;
        hub_reset_d    = abort || start_ok || done_entry;
        if (start_ok) begin
            // The port width already bounds pre_len to DEPTH-1.
            pre_len_d  = pre_len;
            post_len_d = (post_len == '0) ? ADDR_WIDTH'(1) : post_len;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            done_d     = 1'b0;
        end else if (abort) begin
            done_d = 1'b0;
        end else begin
            case (state_q)
                CAP_PRE_FILL:  if (sample_valid) pre_cnt_d = pre_cnt_q + ADDR_WIDTH'(1);
                CAP_WAIT_TRIG: begin
                    if (trig_hit) begin
                        trigger_addr_d = wr_ptr;
                        post_cnt_d     = sample_valid ? ADDR_WIDTH'(1) : '0;
                    end
                end
                CAP_POST_FILL: if (sample_valid) post_cnt_d = post_cnt_q + ADDR_WIDTH'(1);
                default:       ;
            endcase
        end
        if (done_entry) begin
            done_d       = 1'b1;
            start_addr_d = start_sub;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_len_q      <= '0;
            post_len_q     <= '0;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            trigger_addr_q <= '0;
            start_addr_q   <= '0;
            done_q         <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            hub_reset_q    <= 1'b0;
        end else begin
            pre_len_q      <= pre_len_d;
            post_len_q     <= post_len_d;
            pre_cnt_q      <= pre_cnt_d;
            post_cnt_q     <= post_cnt_d;
            trigger_addr_q <= trigger_addr_d;
            start_addr_q   <= start_addr_d;
            done_q         <= done_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            hub_reset_q    <= hub_reset_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign trigger_addr = trigger_addr_q;
    assign start_addr   = start_addr_q;
    assign done         = done_q;
    assign hub_reset    = hub_reset_q;

endmodule

// File: doc/mso_capture_ctrl.md
Name: mso_capture_ctrl

Overview:
- Capture sequencer directly downstream of the MSO trigger hub. It consumes the hub's 2-bit trigger state and drives the hub's arm/reset inputs.
- Writes qualified samples into a circular sample RAM: pre-trigger fill, wait for trigger, post-trigger fill, then stop.
- Reports the trigger and start addresses so readout can unroll the ring.

Parameters:
ADDR_WIDTH, 10, sample RAM address width; DEPTH = 2^ADDR_WIDTH
DATA_WIDTH, 16, sample word width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle capture request
abort  in  1  single-cycle abort request
pre_len  in  ADDR_WIDTH  pre-trigger sample count
post_len  in  ADDR_WIDTH  post-trigger sample count
sample_valid  in  1  sample qualifier
sample_data  in  DATA_WIDTH  sample word
trigger_state  in  2  hub state: 0 disarmed, 1 armed, 2 triggered, 3 cleared
hub_arm  out  1  arm request to hub
hub_reset  out  1  reset request to hub
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_WIDTH  RAM write address
wr_data  out  DATA_WIDTH  RAM write data
trigger_addr  out  ADDR_WIDTH  RAM address of the first post-trigger sample
start_addr  out  ADDR_WIDTH  RAM address of the oldest captured sample
busy  out  1  capture in progress
done  out  1  capture complete (level)
cap_state  out  3  FSM state, for debug

Behaviour:
- Reset: rst_n low forces IDLE immediately; every output and counter is 0.
- States: IDLE=0, PRE_FILL=1, WAIT_TRIG=2, POST_FILL=3, DONE=4.
- Config latch:
  - pre_len and post_len are latched on start.
  - pre_len is clamped to DEPTH-1.
  - post_len of 0 is treated as 1.
  - pre + post exceeding DEPTH is legal; the oldest pre samples are overwritten.
- Write path:
  - In PRE_FILL, WAIT_TRIG and POST_FILL, each sample_valid produces wr_en=1 exactly one cycle later, with registered wr_data and wr_addr.
  - Write pointer increments mod DEPTH after each write; wraps DEPTH-1 -> 0.
  - wr_en is 0 in IDLE and DONE.
- IDLE/DONE, start=1:
  - Pointer := 0, counters := 0, done := 0.
  - hub_reset pulses high for 1 cycle; next state PRE_FILL.
- PRE_FILL:
  - pre_cnt counts valid samples.
  - When pre_cnt == pre_len, go to WAIT_TRIG next cycle. If pre_len=0, this happens on the first PRE_FILL cycle.
- WAIT_TRIG:
  - hub_arm = (state==WAIT_TRIG) && (trigger_state==0). This is a decode of registered signals only, so no combinational loop.
  - Samples keep being written into the ring.
  - Trigger-detect cycle (trigger_state==2 or 3):
    - trigger_addr := current write pointer.
    - The sample in that cycle, if valid, is written there and counts as post sample 1.
    - Next state POST_FILL, or DONE if post_len==1 and sample_valid was high.
- POST_FILL:
  - post_cnt counts valid samples.
  - On the valid sample where post_cnt reaches post_len, next state DONE.
- DONE entry:
  - done=1 and busy=0.
  - start_addr := (trigger_addr - pre_len) mod DEPTH.
  - hub_reset pulses 1 cycle.
  - done holds until the next start or abort.
- busy is 1 in PRE_FILL, WAIT_TRIG and POST_FILL.
- abort, from any state:
  - Next state IDLE; hub_reset pulses 1 cycle.
  - Writes stop: no wr_en for samples arriving on or after the abort cycle.
  - done := 0; trigger_addr and start_addr are kept.
- Simultaneous start and abort: abort wins.
- start while busy: ignored.
- trigger_state changing from 2 to 3 during POST_FILL has no effect.
- A hub drop to 0 during POST_FILL has no effect; capture completes.

Decomposition:
- Shared package mso_pkg: trigger-state encodings (TRIG_DISARMED/ARMED/TRIGGERED/CLEARED), common to this block and the hub, plus the capture FSM encodings.
- One sub-module: mso_ring_addr. It is a mod-DEPTH write-pointer counter with clear and increment, and provides the (ptr - n) mod DEPTH subtract used for start_addr.

Test Plan:
All scenarios use ADDR_WIDTH=4, DEPTH=16.
- pre=4, post=4, continuous valid, trigger_state->2 after 7 valid samples in WAIT_TRIG.
  -> 4 + 7 + 4 = 15 writes at addresses 0..14; trigger_addr=11; start_addr=7; done=1; hub_reset pulses twice.
- pre=4, post=6, trigger held off until the pointer reaches 14.
  -> Writes wrap 15 -> 0; trigger_addr=14; last write at address 3; start_addr=10.
- hub_arm:
  - Stays high from WAIT_TRIG entry while trigger_state=0.
  - Drops the cycle trigger_state=1.
  - Pre-fill samples with sample_valid toggling 1010 take 8 cycles for pre=4.
- pre=0, post=0.
  -> WAIT_TRIG on the first cycle after start; a valid sample in the trigger-detect cycle completes capture; exactly 1 post write; done next cycle.
- abort in the same cycle as start, and abort in WAIT_TRIG.
  -> IDLE, hub_reset pulses once, busy=0, done=0, no further wr_en.
- rst_n low in POST_FILL after 2 of 4 post samples.
  -> Outputs 0 immediately; cap_state=0; a subsequent start runs a clean capture from address 0.
